// File: rtl/vga_pixel_fetch_if.sv
// Framebuffer read port: request/address out, same-cycle ack with data back.
interface vga_pixel_fetch_if #(
    parameter int ADDR_W  = 17,
    parameter int PIXEL_W = 8
);
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [PIXEL_W-1:0] mem_data;

    modport master (output mem_req, mem_addr, input mem_ack, mem_data);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/vga_pixel_fetch.sv
// 2x-scaled 320x240 framebuffer fetch: per-row prefetch into a ping-pong line
// buffer and a fixed two-cycle display pipeline with aligned sync outputs.
module vga_pixel_fetch #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int SRC_W   = 320,
    parameter int SRC_H   = 240,
    parameter int ADDR_W  = 17,
    parameter int PIXEL_W = 8,
    parameter int FB_BASE = 0
) (
    input  logic               clock_25mhz,
    input  logic               reset_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               in_active_area,
    vga_pixel_fetch_if.master  mem,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               active_out,
    output logic               underrun
);
    localparam int COL_W = $clog2(SRC_W);
    localparam int ROW_W = $clog2(SRC_H);

    typedef enum logic {IDLE, FETCH} state_e;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_t;

    localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d, trig_row;
    logic [COL_W-1:0]   col_q, col_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d, trig_addr;
    logic               underrun_q, underrun_d;
    logic               trig, wr_en;

    logic [PIXEL_W-1:0] lbuf [2][SRC_W];

    logic [8:0]         s1_col_q, s1_col_d;
    logic               s1_bank_q, s1_bank_d;
    sync_t              sync_in;
    sync_t [1:0]        sync_q, sync_d;
    logic [PIXEL_W-1:0] pixel_q, pixel_d;

    // Row 0 is fetched two lines before the frame wraps; every even visible
    // line then fetches the row after the one currently on screen.
    always_comb begin
        trig     = 1'b0;
        trig_row = '0;
        if (x == '0) begin
            if (y == 10'(V_TOTAL - 2)) begin
                trig = 1'b1;
            end else if (!y[0] && y <= 10'(2 * (SRC_H - 2))) begin
                trig     = 1'b1;
                trig_row = ROW_W'(y[9:1]) + ROW_W'(1);
            end
        end
        trig_addr = ADDR_W'(FB_BASE) + ADDR_W'(trig_row) * ADDR_W'(SRC_W);
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        underrun_d = underrun_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d    = FETCH;
                    row_d      = trig_row;
                    col_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = trig_addr;
                end
            end
            FETCH: begin
                // An ack coinciding with a retrigger still lands for the old row.
                wr_en = mem.mem_ack;
                if (trig) begin
                    underrun_d = 1'b1;
                    row_d      = trig_row;
                    col_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = trig_addr;
                end else if (mem.mem_ack) begin
                    if (col_q == COL_W'(SRC_W - 1)) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end else begin
                        col_d      = col_q + COL_W'(1);
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_25mhz) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clock_25mhz) begin
        if (reset_n && wr_en)
            lbuf[row_q[0]][col_q] <= mem.mem_data;
    end

    // Display side: stage 1 captures the source coordinate, stage 2 reads.
    always_comb begin
        sync_in   = '{hs: hsync, vs: vsync, act: in_active_area && (x < 10'(H_TOTAL))};
        s1_col_d  = x[9:1];
        s1_bank_d = y[1];
        sync_d    = {sync_q[0], sync_in};
        pixel_d   = '0;
        if (sync_q[0].act)
            pixel_d = lbuf[s1_bank_q][s1_col_q];
    end

    always_ff @(posedge clock_25mhz) begin
        if (!reset_n) begin
            s1_col_q  <= '0;
            s1_bank_q <= 1'b0;
            sync_q    <= {SYNC_RST, SYNC_RST};
            pixel_q   <= '0;
        end else begin
            s1_col_q  <= s1_col_d;
            s1_bank_q <= s1_bank_d;
            sync_q    <= sync_d;
            pixel_q   <= pixel_d;
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign pixel_out    = pixel_q;
    assign hsync_out    = sync_q[1].hs;
    assign vsync_out    = sync_q[1].vs;
    assign active_out   = sync_q[1].act;
    assign underrun     = underrun_q;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: prefetch sequencing, pipeline alignment,
// line doubling, underrun handling and a slow-memory multi-line run.
module tb_vga_pixel_fetch;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] x, y;
    logic       hs, vs, act;
    logic [7:0] pixel_out;
    logic       hsync_out, vsync_out, active_out, underrun;

    int ack_mode = 1;   // 0: never ack, 1: ack every cycle, 2: ack on 4th cycle of a request
    int wcnt     = 0;
    int total    = 0;
    int bad      = 0;

    always #20 clk = ~clk;

    vga_pixel_fetch_if #(.ADDR_W(17), .PIXEL_W(8)) mif ();

    assign mif.mem_data = mif.mem_addr[7:0];
    assign mif.mem_ack  = (ack_mode == 1) ? 1'b1 :
                          (ack_mode == 2) ? (mif.mem_req && wcnt == 3) : 1'b0;

    always @(posedge clk) wcnt <= (mif.mem_req && !mif.mem_ack) ? wcnt + 1 : 0;

    vga_pixel_fetch dut (
        .clock_25mhz   (clk),
        .reset_n       (reset_n),
        .x             (x),
        .y             (y),
        .hsync         (hs),
        .vsync         (vs),
        .in_active_area(act),
        .mem           (mif),
        .pixel_out     (pixel_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .active_out    (active_out),
        .underrun      (underrun)
    );

    typedef struct {
        int x, y, hs, vs, act, pix;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int xi, input int yi, input int hsi, input int vsi, input int acti);
        x   = 10'(xi);
        y   = 10'(yi);
        hs  = 1'(hsi);
        vs  = 1'(vsi);
        act = 1'(acti);
        @(posedge clk);
        #1;
    endtask

    // Trigger at x=0 on line yy, then expect 320 back-to-back addresses from base.
    task automatic fill_check(input int yy, input int base);
        step(0, yy, 1, 1, 0);
        chk("fill_req_first", 32'(mif.mem_req), 1);
        chk("fill_addr_first", 32'(mif.mem_addr), base);
        for (int k = 1; k < 320; k++) begin
            step(k, yy, 1, 1, 0);
            chk("fill_req", 32'(mif.mem_req), 1);
            chk("fill_addr", 32'(mif.mem_addr), base + k);
        end
        step(320, yy, 1, 1, 0);
        chk("fill_req_done", 32'(mif.mem_req), 0);
    endtask

    vec_t vt[8];
    vec_t prev;
    int   have_prev;
    int   yy, hsg, vsg, acg, pe;

    initial begin
        vt[0] = '{x: 10,  y: 0, hs: 1, vs: 0, act: 1, pix: 5};
        vt[1] = '{x: 11,  y: 0, hs: 0, vs: 1, act: 1, pix: 5};
        vt[2] = '{x: 12,  y: 0, hs: 1, vs: 1, act: 1, pix: 6};
        vt[3] = '{x: 700, y: 0, hs: 0, vs: 1, act: 0, pix: 0};
        vt[4] = '{x: 639, y: 0, hs: 1, vs: 0, act: 1, pix: 63};
        vt[5] = '{x: 20,  y: 1, hs: 1, vs: 1, act: 1, pix: 10};
        vt[6] = '{x: 21,  y: 1, hs: 0, vs: 0, act: 1, pix: 10};
        vt[7] = '{x: 700, y: 1, hs: 1, vs: 1, act: 0, pix: 0};

        // Reset, then reset again in the middle of a fill
        reset_n = 1'b0;
        step(5, 100, 1, 1, 0);
        step(5, 100, 1, 1, 0);
        reset_n = 1'b1;
        step(0, 523, 1, 1, 0);
        step(1, 523, 1, 1, 0);
        step(2, 523, 1, 1, 0);
        chk("pre_reset_req", 32'(mif.mem_req), 1);
        reset_n = 1'b0;
        step(3, 523, 0, 0, 1);
        chk("rst_req", 32'(mif.mem_req), 0);
        chk("rst_addr", 32'(mif.mem_addr), 0);
        chk("rst_pixel", 32'(pixel_out), 0);
        chk("rst_hsync", 32'(hsync_out), 1);
        chk("rst_vsync", 32'(vsync_out), 1);
        chk("rst_active", 32'(active_out), 0);
        chk("rst_underrun", 32'(underrun), 0);
        for (int i = 0; i < 3; i++) begin
            step(4 + i, 523, 0, 0, 1);
            chk("rst_hold_req", 32'(mif.mem_req), 0);
        end
        reset_n = 1'b1;
        step(7, 523, 1, 1, 0);
        chk("idle_after_rst", 32'(mif.mem_req), 0);

        // Row 0 prefetch at full rate
        ack_mode = 1;
        fill_check(523, 0);

        // Pixel / sync alignment and line doubling, two-cycle latency
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) step(vt[i].x, vt[i].y, vt[i].hs, vt[i].vs, vt[i].act);
            else       step(700, 1, 1, 1, 0);
            if (i >= 1) begin
                chk("vec_pixel", 32'(pixel_out), vt[i-1].pix);
                chk("vec_hsync", 32'(hsync_out), vt[i-1].hs);
                chk("vec_vsync", 32'(vsync_out), vt[i-1].vs);
                chk("vec_active", 32'(active_out), vt[i-1].act);
            end
        end

        // Row 1 into bank 1, then shown on line 2 while row 2 fills bank 0
        fill_check(0, 320);
        step(0, 2, 1, 1, 1);
        chk("row2_addr_first", 32'(mif.mem_addr), 640);
        step(1, 2, 1, 1, 1);
        chk("y2_pixel_addr320", 32'(pixel_out), 64);
        for (int k = 2; k <= 320; k++) step(k, 2, 1, 1, 0);
        chk("row2_done", 32'(mif.mem_req), 0);
        chk("no_underrun_yet", 32'(underrun), 0);

        // Stalled memory: retrigger mid-fill sets the sticky underrun flag
        ack_mode = 0;
        step(0, 0, 1, 1, 0);
        chk("stall_req", 32'(mif.mem_req), 1);
        chk("stall_addr", 32'(mif.mem_addr), 320);
        step(1, 0, 1, 1, 0);
        step(2, 0, 1, 1, 0);
        chk("stall_addr_hold", 32'(mif.mem_addr), 320);
        chk("stall_no_underrun", 32'(underrun), 0);
        step(0, 2, 1, 1, 0);
        chk("underrun_set", 32'(underrun), 1);
        chk("restart_addr", 32'(mif.mem_addr), 640);
        chk("restart_req", 32'(mif.mem_req), 1);
        ack_mode = 1;
        for (int k = 1; k <= 320; k++) step(k, 2, 1, 1, 0);
        chk("restart_fill_done", 32'(mif.mem_req), 0);
        chk("underrun_sticky", 32'(underrun), 1);
        step(10, 4, 1, 1, 1);
        step(11, 4, 1, 1, 1);
        chk("row2_pixel", 32'(pixel_out), 133);
        chk("underrun_sticky2", 32'(underrun), 1);

        // Slow memory over real line timing, every output compared
        ack_mode = 2;
        reset_n  = 1'b0;
        step(5, 100, 1, 1, 0);
        step(5, 100, 1, 1, 0);
        chk("underrun_cleared", 32'(underrun), 0);
        reset_n   = 1'b1;
        have_prev = 0;
        for (int li = 0; li < 8; li++) begin
            yy = (li < 2) ? 523 + li : li - 2;
            for (int xx = 0; xx < 800; xx++) begin
                if (xx == 0 && (yy == 0 || yy == 2 || yy == 4))
                    chk("slow_fill_in_budget", 32'(mif.mem_req), 0);
                hsg = (xx >= 656 && xx < 752) ? 0 : 1;
                vsg = (yy >= 490 && yy < 492) ? 0 : 1;
                acg = (xx < 640 && yy < 480) ? 1 : 0;
                step(xx, yy, hsg, vsg, acg);
                if (have_prev != 0) begin
                    pe = (prev.act != 0) ? (((prev.y / 2) * 320 + prev.x / 2) % 256) : 0;
                    chk("slow_pixel", 32'(pixel_out), pe);
                    chk("slow_hsync", 32'(hsync_out), prev.hs);
                    chk("slow_active", 32'(active_out), prev.act);
                end
                prev      = '{x: xx, y: yy, hs: hsg, vs: vsg, act: acg, pix: 0};
                have_prev = 1;
            end
        end
        chk("slow_no_underrun", 32'(underrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Sits directly downstream of vga_driver, in the 25 MHz pixel domain.
- Consumes the driver's x, y, hsync, vsync and in_active_area; produces pixel data for the DAC, with the sync signals delayed to stay aligned with it.
- The framebuffer is 320x240 and is scaled 2x in each direction to fill 640x480.
- Each source row is prefetched from external framebuffer memory into a ping-pong line buffer one source row ahead of display.

Parameters:
- H_TOTAL, 800, clocks per line (matches the driver's timing).
- V_TOTAL, 525, lines per frame.
- SRC_W, 320, source pixels per row.
- SRC_H, 240, source rows.
- ADDR_W, 17, framebuffer word address width.
- PIXEL_W, 8, pixel data width.
- FB_BASE, 0, framebuffer base word address.

Ports:
- clock_25mhz  in  1  pixel clock; all logic is on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- x  in  10  driver horizontal counter.
- y  in  10  driver vertical counter.
- hsync  in  1  driver hsync.
- vsync  in  1  driver vsync.
- in_active_area  in  1  driver active-video flag.
- mem_req  out  1  read request to the framebuffer.
- mem_addr  out  ADDR_W  read word address.
- mem_ack  in  1  read accepted; mem_data is valid in the same cycle.
- mem_data  in  PIXEL_W  read data.
- pixel_out  out  PIXEL_W  pixel to the DAC.
- hsync_out  out  1  hsync delayed by 2 cycles.
- vsync_out  out  1  vsync delayed by 2 cycles.
- active_out  out  1  in_active_area delayed by 2 cycles.
- underrun  out  1  sticky flag: a fill was still incomplete when the next fill was triggered.

Behaviour:
- One clock, clock_25mhz; reset is synchronous and active-low (reset_n). All logic is on the rising edge.
- Reset values:
  - mem_req=0, mem_addr=0, pixel_out=0, active_out=0, underrun=0.
  - hsync_out=1, vsync_out=1 (inactive).
  - FSM=IDLE.
  - Line buffer contents are not cleared.
- Line buffer: two banks of SRC_W x PIXEL_W. Source row r lives in bank r[0].
- Fill trigger: a single-cycle event at x==0 and
  - y==V_TOTAL-2 (523): fill source row 0;
  - y even and y<=2*(SRC_H-2) (0..476): fill row y/2+1.
  - No other lines trigger a fill.
- Fill FSM:
  - IDLE: on trigger, latch row, set col=0, go to FETCH.
  - FETCH:
    - mem_req=1 and mem_addr=FB_BASE+row*SRC_W+col, both registered.
    - On mem_ack: write mem_data to bank[row[0]][col], increment col.
    - When col==SRC_W-1 is acked: mem_req=0 next cycle, go to IDLE.
    - Otherwise the next address is presented the cycle after the ack, so throughput is 1 word/cycle when mem_ack is tied high.
  - mem_req stays high until acked. mem_addr is stable while mem_req=1 and not acked.
- Fill budget: 1600 clocks, i.e. 2 lines, per row. The memory must average at most 5 clocks per word.
- Trigger while in FETCH:
  - underrun <= 1 (sticky until reset).
  - The current fill is abandoned; the new row is latched and col=0, with the new mem_addr presented next cycle and FETCH retained.
  - An ack arriving in the same cycle as the trigger is written for the old row, then the fill restarts.
- Display pipeline, fixed latency of 2 cycles:
  - Stage 1 registers col_d=x[9:1], bank_d=y[1] (source row y[9:1], bank = its LSB), plus the sync/active inputs.
  - Stage 2 reads the buffer: pixel_out = active ? bank[bank_d][col_d] : 0. The sync/active signals are registered again.
- A bank is never read and written in the same cycle, because the fill targets the non-displayed bank (normal case).
- Sync polarity passes through unchanged.
- The driver's x/y are assumed in range; behaviour for x>=H_TOTAL or y>=V_TOTAL is undefined.
- Reset mid-fill: next edge mem_req=0, FSM=IDLE. No further buffer writes occur; the next trigger restarts cleanly.

Test Plan:
1. Reset: hold reset_n=0 for 4 cycles during a FETCH -> next edge mem_req=0, pixel_out=0, hsync_out=vsync_out=1, underrun=0.
2. Row-0 prefetch: y=523, x=0; mem_ack tied 1; mem_data=mem_addr[7:0] -> 320 consecutive requests at addresses 0..319, one per cycle; mem_req low on the 322nd cycle.
3. Pixel alignment: after test 2, y=0, x=10, active=1 -> pixel_out=5 two cycles later; hsync_out/active_out equal their inputs from 2 cycles earlier. At x=700 (inactive) -> pixel_out=0.
4. Line doubling: y=1, x=10 shows 5 (same as y=0). Row 1 fill, triggered at y=0, uses addresses 320..639 (bank 1). At y=2, x=0 -> pixel_out=mem_data of address 320.
5. Underrun: mem_ack held 0 from y=0 onward; trigger at y=2, x=0 -> underrun=1 the next cycle, mem_addr=640 (row 2); flag stays 1 after later good fills.
6. Slow memory: ack 4 cycles after each req throughout a frame -> all fills complete within budget, underrun stays 0, and every displayed pixel equals its addressed data.
